// File: rtl/bcd_bin_if.sv
// Handshake and data bundle for the BCD-to-binary sequencer.
//   start  : conversion request (master -> slave)
//   bcd_in : packed BCD digits, MSD in the top nibble (master -> slave)
//   binary : converted result (slave -> master)
//   busy   : conversion in progress (slave -> master)
//   done   : one-cycle result-valid pulse (slave -> master)
//   err    : input held a nibble > 9 (slave -> master)
interface bcd_bin_if #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic [BIN_W-1:0]      binary;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (output start, output bcd_in,
                    input  binary, input busy, input done, input err);
    modport slave  (input  start, input bcd_in,
                    output binary, output busy, output done, output err);
endinterface

// File: rtl/bcd_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double dabble), one bit per clock.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : bcd_bin_if slave (start/bcd_in in; binary/busy/done/err out)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; latches bcd_in and checks digit validity
// SHIFT | one shift-right + subtract-3 iteration per clock, BIN_W total
// DONE  | publishes binary/err, pulses done on the following cycle
module bcd_bin_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14,
    parameter int CNT_W  = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    bcd_bin_if.slave bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [SR_W-1:0]    sr, sr_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [BIN_W-1:0]   bin_q, bin_nxt;
    logic               busy_q, busy_nxt;
    logic               done_q, done_nxt;
    logic               err_q, err_nxt;
    logic               bad_q, bad_nxt;

    logic [SR_W-1:0]    shifted;
    logic [SR_W-1:0]    stepped;
    logic               any_bad;

    // One iteration: shift, then correct every BCD nibble that went >= 8.
    // The correction never borrows because it only applies to values 8..15.
    always_comb begin
        shifted = sr >> 1;
        stepped = shifted;
        for (int i = 0; i < DIGITS; i++) begin
            if (shifted[BIN_W + 4*i + 3])
                stepped[BIN_W + 4*i +: 4] = shifted[BIN_W + 4*i +: 4] - 4'd3;
        end
    end

    always_comb begin
        any_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.bcd_in[4*i +: 4] > 4'd9)
                any_bad = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        cnt_nxt   = cnt;
        bin_nxt   = bin_q;
        busy_nxt  = busy_q;
        done_nxt  = 1'b0;
        err_nxt   = err_q;
        bad_nxt   = bad_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    sr_nxt  = {bus.bcd_in, {BIN_W{1'b0}}};
                    cnt_nxt = '0;
                    if (any_bad) begin
                        bad_nxt   = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        bad_nxt   = 1'b0;
                        busy_nxt  = 1'b1;
                        state_nxt = SHIFT;
                    end
                end
            end
            SHIFT: begin
                sr_nxt  = stepped;
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == CNT_W'(BIN_W - 1)) begin
                    busy_nxt  = 1'b0;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // done is registered here so it becomes visible in the
                // following IDLE cycle, never overlapping busy.
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                if (bad_q) begin
                    bin_nxt = '0;
                    err_nxt = 1'b1;
                end else begin
                    bin_nxt = sr[BIN_W-1:0];
                    err_nxt = 1'b0;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sr     <= '0;
            cnt    <= '0;
            bin_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            bad_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            sr     <= sr_nxt;
            cnt    <= cnt_nxt;
            bin_q  <= bin_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
            err_q  <= err_nxt;
            bad_q  <= bad_nxt;
        end
    end

    assign bus.binary = bin_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_bcd_bin_seq.sv
// Self-checking bench for bcd_bin_seq with a decimal-arithmetic reference model.
module tb_bcd_bin_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    bcd_bin_if #(.DIGITS(4), .BIN_W(14)) bus ();

    bcd_bin_seq #(.DIGITS(4), .BIN_W(14), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: interpret nibbles as decimal digits, flag any nibble > 9.
    function automatic void model(input logic [15:0] b, output int val, output logic bad);
        logic [15:0] t;
        t = b;
        val = 0;
        bad = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            int d;
            d = int'(t[4*i +: 4]);
            if (d > 9) bad = 1'b1;
            val = val * 10 + d;
        end
        if (bad) val = 0;
    endfunction

    // Stimulus/measurement only: one conversion, returns what was observed.
    task automatic run_conv(input logic [15:0] b, output logic [13:0] bin, output logic e,
                            output int lat, output int busy_cyc, output logic to,
                            output logic held);
        logic [13:0] prev;
        @(negedge clk);
        bus.bcd_in = b;
        bus.start  = 1'b1;
        prev = bus.binary;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.bcd_in = 16'($urandom);
        lat = 0; busy_cyc = 0; to = 1'b0; held = 1'b1;
        if (bus.busy) busy_cyc++;
        while (!bus.done) begin
            if (lat >= 40) begin to = 1'b1; break; end
            if (bus.binary !== prev) held = 1'b0;
            @(posedge clk); #1;
            lat++;
            if (bus.busy) busy_cyc++;
        end
        bin = bus.binary;
        e = bus.err;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.bcd_in = '0;
        #12;
        n_checks++;
        if ({bus.binary, bus.busy, bus.done, bus.err} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got bin=%0d busy=%b done=%b err=%b, need all 0",
                     bus.binary, bus.busy, bus.done, bus.err);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_valid(input logic [15:0] b);
        logic [13:0] bin; logic e, to, held; int lat, bc, ev; logic eb;
        model(b, ev, eb);
        run_conv(b, bin, e, lat, bc, to, held);
        n_checks++;
        if (to || bin !== 14'(ev) || e !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_%h: got bin=%0d err=%b timeout=%b, need bin=%0d err=0", b, bin, e, to, ev);
        end
        n_checks++;
        if (lat !== 15 || bc !== 14) begin
            n_fail++;
            $display("FAIL latency_%h: got done@%0d busy_cycles=%0d, need 15 and 14", b, lat, bc);
        end
        n_checks++;
        if (!held) begin
            n_fail++;
            $display("FAIL hold_%h: binary changed while converting, need stable", b);
        end
    endtask

    task automatic test_invalid(input logic [15:0] b);
        logic [13:0] bin; logic e, to, held; int lat, bc, ev; logic eb;
        model(b, ev, eb);
        run_conv(b, bin, e, lat, bc, to, held);
        n_checks++;
        if (to || bin !== 14'd0 || e !== eb || lat !== 1 || bc !== 0) begin
            n_fail++;
            $display("FAIL invalid_%h: got bin=%0d err=%b lat=%0d busy=%0d, need bin=0 err=%b lat=1 busy=0",
                     b, bin, e, lat, bc, eb);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 20; k++) begin
            logic [15:0] b;
            for (int i = 0; i < 4; i++) b[4*i +: 4] = 4'($urandom_range(0, 9));
            test_valid(b);
        end
        for (int k = 0; k < 6; k++) begin
            logic [15:0] b;
            for (int i = 0; i < 4; i++) b[4*i +: 4] = 4'($urandom_range(0, 9));
            b[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
            test_invalid(b);
        end
    endtask

    task automatic test_ignore_start();
        int dones; logic [13:0] first;
        dones = 0; first = '0;
        @(negedge clk);
        bus.bcd_in = 16'h0321; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 4) begin bus.start = 1'b1; bus.bcd_in = 16'h0777; end
            if (c == 8) bus.start = 1'b0;
            @(posedge clk); #1;
            if (bus.done) begin
                if (dones == 0) first = bus.binary;
                dones++;
            end
        end
        n_checks++;
        if (dones !== 1 || first !== 14'd321) begin
            n_fail++;
            $display("FAIL ignore_start: got dones=%0d bin=%0d, need 1 and 321", dones, first);
        end
    endtask

    task automatic test_reset_mid();
        int dones; logic [13:0] bin; logic e, to, held; int lat, bc;
        dones = 0;
        @(negedge clk);
        bus.bcd_in = 16'h0500; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.binary, bus.busy, bus.done, bus.err} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got bin=%0d busy=%b done=%b err=%b, need all 0",
                     bus.binary, bus.busy, bus.done, bus.err);
        end
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        n_checks++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL reset_no_done: got %0d done pulses, need 0", dones);
        end
        run_conv(16'h0500, bin, e, lat, bc, to, held);
        n_checks++;
        if (to || bin !== 14'd500 || e !== 1'b0 || lat !== 15) begin
            n_fail++;
            $display("FAIL after_reset: got bin=%0d err=%b lat=%0d, need 500 0 15", bin, e, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ins [3];
        int t [3]; int v [3]; int ev; logic eb; logic to;
        ins[0] = 16'h0001; ins[1] = 16'h0010; ins[2] = 16'h0100;
        to = 1'b0;
        @(negedge clk);
        bus.bcd_in = ins[0]; bus.start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            int w;
            w = 0;
            t[k] = 0; v[k] = -1;
            do begin
                @(posedge clk); #1;
                w++;
            end while (!bus.done && w < 40);
            if (!bus.done) to = 1'b1;
            t[k] = cyc; v[k] = int'(bus.binary);
            if (k < 2) bus.bcd_in = ins[k+1];
            else bus.start = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            model(ins[k], ev, eb);
            n_checks++;
            if (to || v[k] !== ev) begin
                n_fail++;
                $display("FAIL b2b_value%0d: got %0d timeout=%b, need %0d", k, v[k], to, ev);
            end
        end
        n_checks++;
        if (t[1] - t[0] !== 16 || t[2] - t[1] !== 16) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d and %0d cycles, need 16 and 16", t[1]-t[0], t[2]-t[1]);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_stop: got busy=%b after start dropped, need 0", bus.busy);
        end
    endtask

    initial begin
        test_reset();
        test_valid(16'h1234);
        test_valid(16'h9999);
        test_valid(16'h0000);
        test_invalid(16'h12A4);
        test_random();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
